// File: rtl/vec_group_regfile.sv
// Vector register file: LMUL-grouped combinational reads, beat-serial group write FSM, v0 mask port.
// Optional macro VRF_WRITE_FORWARD_EN forwards the active write beat onto the read ports.
module vec_group_regfile #(
  parameter int unsigned VLEN     = 512,
  parameter int unsigned NREG     = 32,
  parameter int unsigned MAX_LMUL = 8,
  localparam int unsigned AW = $clog2(NREG),
  localparam int unsigned DW = MAX_LMUL * VLEN,
  localparam int unsigned LW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   raddr_1,
  input  logic [AW-1:0]   raddr_2,
  input  logic [AW-1:0]   dst_addr,
  input  logic [3:0]      lmul,
  output logic [DW-1:0]   rdata_1,
  output logic [DW-1:0]   rdata_2,
  output logic [DW-1:0]   dst_data,
  output logic [LW-1:0]   vector_length,
  output logic            wrong_addr,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            mask_wr_en,
  output logic [VLEN-1:0] v0_mask_data,
  output logic            data_written,
  output logic            wr_err
);

  localparam int unsigned BW = $clog2(MAX_LMUL + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [AW-1:0]   cap_addr;
  logic [3:0]      cap_lmul;
  logic [DW-1:0]   cap_data;
  logic [VLEN-1:0] regs [NREG];
  logic [VLEN-1:0] view [NREG];
  logic            accept, cap_bad, beat_wen, err_d, done_d;
  logic [AW-1:0]   beat_addr;
  logic [VLEN-1:0] beat_word;

  function automatic logic lmul_legal(input logic [3:0] lm);
    return (lm == 4'd1 || lm == 4'd2 || lm == 4'd4 || lm == 4'd8) && (32'(lm) <= MAX_LMUL);
  endfunction

  // Group must be legal-sized, aligned to its size, and fit inside the file.
  function automatic logic cfg_bad(input logic [AW-1:0] addr, input logic [3:0] lm);
    if (!lmul_legal(lm)) return 1'b1;
    return ((32'(addr) & (32'(lm) - 32'd1)) != 32'd0) || ((32'(addr) + 32'(lm)) > NREG);
  endfunction

  assign wr_ready      = (state_q == IDLE) && !mask_wr_en;
  assign accept        = wr_valid && wr_ready;
  assign cap_bad       = cfg_bad(cap_addr, cap_lmul);
  assign beat_addr     = AW'(32'(cap_addr) + 32'(beat_q));
  assign beat_word     = cap_data[32'(beat_q)*VLEN +: VLEN];
  assign wrong_addr    = cfg_bad(raddr_1, lmul) | cfg_bad(raddr_2, lmul) | cfg_bad(dst_addr, lmul);
  assign vector_length = lmul_legal(lmul) ? LW'(32'(lmul) * VLEN) : '0;
  assign v0_mask_data  = regs[0];

  // Write FSM next-state and control
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    beat_wen = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WRITE;
          beat_d  = '0;
        end
      end
      WRITE: begin
        if (cap_bad) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          beat_wen = 1'b1;
          beat_d   = beat_q + BW'(1);
          if (32'(beat_q) == (32'(cap_lmul) - 32'd1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      data_written <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      data_written <= done_d;
      wr_err       <= err_d;
    end
  end

  // Request capture; later input changes cannot disturb the write in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_addr <= '0;
      cap_lmul <= '0;
      cap_data <= '0;
    end else if (accept) begin
      cap_addr <= waddr;
      cap_lmul <= lmul;
      cap_data <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
    end else if (beat_wen) begin
      regs[beat_addr] <= beat_word;
    end else if (state_q == IDLE && mask_wr_en) begin
      regs[0] <= wdata[VLEN-1:0];
    end
  end

  always_comb begin
    view = regs;
`ifdef VRF_WRITE_FORWARD_EN
    if (beat_wen) view[beat_addr] = beat_word;
`endif
  end

  // Group reads; zero above lmul*VLEN and on any illegal configuration
  always_comb begin
    rdata_1  = '0;
    rdata_2  = '0;
    dst_data = '0;
    if (!wrong_addr) begin
      for (int unsigned i = 0; i < MAX_LMUL; i++) begin
        if (i < 32'(lmul)) begin
          rdata_1[i*VLEN +: VLEN]  = view[AW'(32'(raddr_1) + i)];
          rdata_2[i*VLEN +: VLEN]  = view[AW'(32'(raddr_2) + i)];
          dst_data[i*VLEN +: VLEN] = view[AW'(32'(dst_addr) + i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_group_regfile.sv
// Bench for vec_group_regfile: queue-based reference model checked every cycle, plus directed literal checks.
module tb_vec_group_regfile;

  localparam int unsigned VLEN     = 512;
  localparam int unsigned NREG     = 32;
  localparam int unsigned MAX_LMUL = 8;
  localparam int unsigned AW       = $clog2(NREG);
  localparam int unsigned DW       = MAX_LMUL * VLEN;
  localparam int unsigned LW       = $clog2(DW) + 1;

  localparam int K_WORD = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   raddr_1, raddr_2, dst_addr, waddr;
  logic [3:0]      lmul;
  logic [DW-1:0]   rdata_1, rdata_2, dst_data, wdata;
  logic [LW-1:0]   vector_length;
  logic            wrong_addr, wr_valid, wr_ready, mask_wr_en, data_written, wr_err;
  logic [VLEN-1:0] v0_mask_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  vec_group_regfile #(.VLEN(VLEN), .NREG(NREG), .MAX_LMUL(MAX_LMUL)) dut (
    .clk(clk), .reset(reset),
    .raddr_1(raddr_1), .raddr_2(raddr_2), .dst_addr(dst_addr), .lmul(lmul),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .dst_data(dst_data),
    .vector_length(vector_length), .wrong_addr(wrong_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .waddr(waddr), .wdata(wdata),
    .mask_wr_en(mask_wr_en), .v0_mask_data(v0_mask_data),
    .data_written(data_written), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted write becomes a queue of pending register updates, one per clock.
  typedef struct {
    int              kind;
    int unsigned     idx;
    logic [VLEN-1:0] data;
  } tok_t;

  tok_t            q[$];
  tok_t            mt;
  logic [VLEN-1:0] m_regs [NREG];
  bit              err_p;
  bit              macc;

  function automatic bit m_bad(input int unsigned a, input int unsigned l);
    if (!(l == 1 || l == 2 || l == 4 || l == 8) || l > MAX_LMUL) return 1'b1;
    if (a % l != 0) return 1'b1;
    if (a + l > NREG) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [VLEN-1:0] m_view(input int unsigned i);
`ifdef VRF_WRITE_FORWARD_EN
    if (q.size() != 0 && q[0].kind == K_WORD && q[0].idx == i) return q[0].data;
`endif
    return m_regs[i];
  endfunction

  function automatic bit m_wrong();
    return m_bad(32'(raddr_1), 32'(lmul)) || m_bad(32'(raddr_2), 32'(lmul)) ||
           m_bad(32'(dst_addr), 32'(lmul));
  endfunction

  function automatic logic [DW-1:0] m_read(input int unsigned a);
    logic [DW-1:0] r;
    r = '0;
    if (m_wrong()) return r;
    for (int unsigned k = 0; k < 32'(lmul); k++) r[k*VLEN +: VLEN] = m_view(a + k);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      q.delete();
      err_p = 1'b0;
    end else begin
      err_p = 1'b0;
      macc  = wr_valid && !mask_wr_en && q.size() == 0;
      if (q.size() != 0) begin
        mt = q.pop_front();
        if (mt.kind == K_WORD) m_regs[mt.idx] = mt.data;
        else if (mt.kind == K_ERR) err_p = 1'b1;
      end else if (mask_wr_en) begin
        m_regs[0] = wdata[VLEN-1:0];
      end
      if (macc) begin
        if (m_bad(32'(waddr), 32'(lmul))) begin
          mt.kind = K_ERR; mt.idx = 0; mt.data = '0;
          q.push_back(mt);
        end else begin
          for (int unsigned k = 0; k < 32'(lmul); k++) begin
            mt.kind = K_WORD; mt.idx = 32'(waddr) + k; mt.data = wdata[k*VLEN +: VLEN];
            q.push_back(mt);
          end
          mt.kind = K_DONE; mt.idx = 0; mt.data = '0;
          q.push_back(mt);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp_wide(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    bit shown;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      shown = 1'b0;
      for (int unsigned w = 0; w < MAX_LMUL; w++) begin
        if (!shown && got[w*VLEN +: VLEN] !== exp[w*VLEN +: VLEN]) begin
          shown = 1'b1;
          $display("FAIL %s t=%0t word %0d got %h expected %h", nm, $time, w,
                   got[w*VLEN +: VLEN], exp[w*VLEN +: VLEN]);
        end
      end
    end
  endtask

  // Every-cycle compare against the model, mid-way between drive and active edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (run && !reset) begin
        lit("wr_ready", 64'(wr_ready), 64'(q.size() == 0 && !mask_wr_en));
        lit("data_written", 64'(data_written), 64'(q.size() == 1 && q[0].kind == K_DONE));
        lit("wr_err", 64'(wr_err), 64'(err_p));
        lit("wrong_addr", 64'(wrong_addr), 64'(m_wrong()));
        lit("vector_length", 64'(vector_length),
            (lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8) ? 64'(lmul) * 64'(VLEN) : 64'd0);
        cmp_wide("rdata_1", rdata_1, m_read(32'(raddr_1)));
        cmp_wide("rdata_2", rdata_2, m_read(32'(raddr_2)));
        cmp_wide("dst_data", dst_data, m_read(32'(dst_addr)));
        lit("v0_mask_data", v0_mask_data[63:0], m_regs[0][63:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] e;
    int lows, errs, dones;

    reset = 1'b1; wr_valid = 1'b0; mask_wr_en = 1'b0; waddr = '0; wdata = '0;
    lmul = 4'd1; raddr_1 = '0; raddr_2 = '0; dst_addr = '0;
    cyc(2);
    reset = 1'b0;
    run   = 1'b1;
    #3;
    lit("reset_ready", 64'(wr_ready), 64'd1);
    lit("reset_v0", v0_mask_data[63:0], 64'd0);
    lit("reset_done", 64'(data_written), 64'd0);
    lit("reset_err", 64'(wr_err), 64'd0);

    // Single lmul=1 write of reg5
    cyc(1);
    lmul = 4'd1; waddr = AW'(5); wdata = '0; wdata[31:0] = 32'hDEADBEEF; wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    #3 lit("busy_after_accept", 64'(wr_ready), 64'd0);
    cyc(1);
    #3 lit("done_pulse_l1", 64'(data_written), 64'd1);
    cyc(1);
    dst_addr = AW'(5);
    #3;
    lit("done_cleared", 64'(data_written), 64'd0);
    e = '0; e[31:0] = 32'hDEADBEEF;
    cmp_wide("dst_reg5", dst_data, e);
    cyc(1);
    lmul = 4'd8; raddr_1 = '0; raddr_2 = AW'(16); dst_addr = AW'(24);
    #3;
    e = '0; e[5*VLEN +: 32] = 32'hDEADBEEF;
    cmp_wide("grp0_after_l1", rdata_1, e);
    cmp_wide("grp16_zero", rdata_2, '0);

    // Group write lmul=4 at reg8, beat k carries k+1
    cyc(1);
    lmul = 4'd4; waddr = AW'(8); raddr_1 = '0; raddr_2 = '0; dst_addr = '0;
    wdata = '0;
    for (int k = 0; k < 4; k++) wdata[k*VLEN +: VLEN] = VLEN'(k + 1);
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (wr_ready) break;
      lows++;
      cyc(1);
    end
    lit("busy_cycles_l4", 64'(lows), 64'd5);
    cyc(1);
    raddr_1 = AW'(8);
    #3;
    e = '0;
    for (int k = 0; k < 4; k++) e[k*VLEN +: VLEN] = VLEN'(k + 1);
    cmp_wide("grp8_l4", rdata_1, e);
    lit("vlen_l4", 64'(vector_length), 64'd2048);

    // Misaligned lmul=8 write must be dropped with wr_err
    cyc(1);
    lmul = 4'd8; waddr = AW'(4); wdata = '1; raddr_1 = '0;
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    errs = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      errs  += int'(wr_err);
      dones += int'(data_written);
      cyc(1);
    end
    lit("err_pulses", 64'(errs), 64'd1);
    lit("no_done_on_err", 64'(dones), 64'd0);
    raddr_1 = AW'(8);
    #3;
    e = '0;
    for (int k = 0; k < 4; k++) e[k*VLEN +: VLEN] = VLEN'(k + 1);
    cmp_wide("grp8_unchanged", rdata_1, e);
    cyc(1);
    raddr_1 = AW'(28);
    #3;
    lit("wrong_addr_28", 64'(wrong_addr), 64'd1);
    cmp_wide("rdata_zero_28", rdata_1, '0);
    lit("vlen_l8", 64'(vector_length), 64'd4096);
    cyc(1);
    lmul = 4'd3; raddr_1 = '0;
    #3;
    lit("vlen_illegal", 64'(vector_length), 64'd0);
    lit("wrong_illegal", 64'(wrong_addr), 64'd1);

    // Mask write in IDLE beats a simultaneous wr_valid
    cyc(1);
    lmul = 4'd1; wdata = '0; wdata[15:0] = 16'hCAFE; waddr = AW'(12);
    mask_wr_en = 1'b1; wr_valid = 1'b1;
    #3 lit("ready_low_mask", 64'(wr_ready), 64'd0);
    cyc(1);
    mask_wr_en = 1'b0; wr_valid = 1'b0;
    #3;
    lit("v0_cafe", v0_mask_data[63:0], 64'hCAFE);
    lit("valid_not_taken", 64'(wr_ready), 64'd1);

    // lmul=2 write at reg2; mask and input churn mid-write; read reg3 during beat 1
    cyc(1);
    lmul = 4'd2; waddr = AW'(2); wdata = '0; wdata[7:0] = 8'h11; wdata[VLEN +: 8] = 8'h22;
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0; mask_wr_en = 1'b1; wdata = '1; waddr = '0;
    cyc(1);
    mask_wr_en = 1'b0; lmul = 4'd1; raddr_2 = AW'(3);
    #3;
    e = '0;
`ifdef VRF_WRITE_FORWARD_EN
    e[7:0] = 8'h22;
`endif
    cmp_wide("beat1_read_reg3", rdata_2, e);
    cyc(2);
    raddr_1 = AW'(2);
    #3;
    lit("reg2_after", rdata_1[63:0], 64'h11);
    lit("reg3_after", rdata_2[63:0], 64'h22);
    lit("v0_kept", v0_mask_data[63:0], 64'hCAFE);

    // Reset during beat 3 of an lmul=8 write at reg0
    cyc(1);
    lmul = 4'd8; waddr = '0; raddr_1 = '0; raddr_2 = '0; dst_addr = '0;
    for (int k = 0; k < 8; k++) wdata[k*VLEN +: VLEN] = VLEN'(32'h100 + k);
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    cyc(3);
    #1;
    lit("v0_beat0_written", v0_mask_data[63:0], 64'h100);
    reset = 1'b1;
    #2;
    lit("v0_async_clear", v0_mask_data[63:0], 64'd0);
    cyc(2);
    reset = 1'b0;
    #3;
    lit("ready_after_reset", 64'(wr_ready), 64'd1);
    cmp_wide("regs_cleared", rdata_1, '0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      #3 dones += int'(data_written);
    end
    lit("no_done_after_abort", 64'(dones), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
